// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate width and small helpers used
// by the display timing generator and its consumers.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;

  localparam logic SYNC_POL_LOW  = 1'b0;
  localparam logic SYNC_POL_HIGH = 1'b1;

  typedef logic [COORD_W-1:0] coord_t;

  // Inclusive window test on a raster coordinate.
  function automatic logic in_span(coord_t pos, coord_t lo, coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// Raster timing bundle handed from the timing generator (master) to the
// colorizer and map/icon lookups (slave).
interface display_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pix_tick;
  coord_t pixel_column;
  coord_t pixel_row;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   hsync_d;
  logic   vsync_d;
  logic   frame_start;

  modport master (
    output pix_tick, pixel_column, pixel_row, video_on,
           hsync, vsync, hsync_d, vsync_d, frame_start
  );

  modport slave (
    input  pix_tick, pixel_column, pixel_row, video_on,
           hsync, vsync, hsync_d, vsync_d, frame_start
  );

endinterface

// File: rtl/display_timing_gen_sync_delay_line.sv
// Two-bit shift register advancing once per pixel tick; re-times hsync/vsync to
// match the colorizer's registered pixel path. DEPTH of zero is a wire.
module sync_delay_line #(
  parameter int         DEPTH   = 1,
  parameter logic [1:0] RST_VAL = 2'b11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [1:0] stage_p [DEPTH];

    // stage boundary: each entry is one pixel tick older than the previous
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
      end else if (en) begin
        stage_p[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign dout = stage_p[DEPTH-1];
  end

endmodule

// File: rtl/display_timing_gen.sv
// Pixel-rate raster generator: divides clk to a one-cycle pixel tick and walks
// the H/V counters, publishing registered position, blanking and sync.
module display_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter logic SYNC_POL   = SYNC_POL_LOW,
  parameter int   CLK_DIV    = 4,
  parameter int   SYNC_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_timing_gen_if.master timing
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  localparam coord_t H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam coord_t V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam coord_t H_ACT   = COORD_W'(H_ACTIVE);
  localparam coord_t V_ACT   = COORD_W'(V_ACTIVE);
  localparam coord_t HS_LO   = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO   = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic   SYNC_IDLE = ~SYNC_POL;

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("display_timing_gen: raster totals exceed the coordinate range");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("display_timing_gen: CLK_DIV must be at least 2");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
    $error("display_timing_gen: SYNC_DELAY must be within 0..7");
  end

  function automatic logic sync_level(coord_t pos, coord_t lo, coord_t hi);
    return in_span(pos, lo, hi) ? SYNC_POL : SYNC_IDLE;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  coord_t           h;
  coord_t           v;
  coord_t           h_next;
  coord_t           v_next;
  logic             h_wrap;
  logic [1:0]       sync_d;

  // stage p0: divider; pix_tick is asserted one cycle ahead of the pixel edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt         <= '0;
      timing.pix_tick <= 1'b0;
    end else begin
      div_cnt         <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      timing.pix_tick <= (div_cnt == DIV_PRE);
    end
  end

  always_comb begin
    h_wrap = (h == H_LAST);
    h_next = h_wrap ? '0 : h + COORD_W'(1);
    v_next = v;
    if (h_wrap) v_next = (v == V_LAST) ? '0 : v + COORD_W'(1);
  end

  // stage p1: position and every decode of it land on the same pixel edge.
  // Counters start at the last position so the first edge lands on (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h                   <= H_LAST;
      v                   <= V_LAST;
      timing.pixel_column <= '0;
      timing.pixel_row    <= '0;
      timing.video_on     <= 1'b0;
      timing.hsync        <= SYNC_IDLE;
      timing.vsync        <= SYNC_IDLE;
      timing.frame_start  <= 1'b0;
    end else begin
      timing.frame_start <= 1'b0;
      if (timing.pix_tick) begin
        h                   <= h_next;
        v                   <= v_next;
        timing.pixel_column <= h_next;
        timing.pixel_row    <= v_next;
        timing.video_on     <= (h_next < H_ACT) && (v_next < V_ACT);
        timing.hsync        <= sync_level(h_next, HS_LO, HS_HI);
        timing.vsync        <= sync_level(v_next, VS_LO, VS_HI);
        timing.frame_start  <= (h_next == '0) && (v_next == '0);
      end
    end
  end

  // stage p2..: sync re-timing toward the colorizer output register
  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (timing.pix_tick),
    .din     ({timing.hsync, timing.vsync}),
    .dout    (sync_d)
  );

  assign timing.hsync_d = sync_d[1];
  assign timing.vsync_d = sync_d[0];

endmodule
